uart_servo_cmd: RTL and testbench

- Command decoder between the UART receiver and the servo PWM generator.
- Consumes the validated byte stream from the receiver and parses 3-byte angle frames.
- Checks each frame, then converts the angle into a pulse width in clock cycles.
- Holds that width stable for the servo PWM stage and flags bad or incomplete frames.

---
 rtl/uart_servo_cmd.sv | 111 +++++++++++
 tb/tb_uart_servo_cmd.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_servo_cmd.sv
// UART-to-servo command decoder: parses HEADER/angle/~angle frames and converts
// an accepted angle into a registered PWM high-time in clock cycles.
module uart_servo_cmd #(
   parameter int          CLK_HZ         = 27000000,
   parameter logic [7:0]  HEADER         = 8'hAA,
   parameter int          MAX_ANGLE      = 180,
   parameter int          MIN_CYCLES     = 27000,
   parameter int          STEP_CYCLES    = 150,
   parameter int          PW_WIDTH       = 20,
   parameter int          TIMEOUT_CYCLES = 270000
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                rx_valid,
   input  logic [7:0]          rx_data,
   output logic [PW_WIDTH-1:0] pulse_width,
   output logic                pw_update,
   output logic [7:0]          angle,
   output logic                frame_err,
   output logic                timeout_err,
   output logic                busy
);
   localparam int                TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]        MAX_A8   = 8'(MAX_ANGLE);
   localparam logic [PW_WIDTH-1:0] PW_RST = PW_WIDTH'(MIN_CYCLES + 90 * STEP_CYCLES);

   // Configuration sanity: the full-scale width must fit in pulse_width.
   if (CLK_HZ <= 0 || MAX_ANGLE > 255 ||
       longint'(MIN_CYCLES) + longint'(MAX_ANGLE) * longint'(STEP_CYCLES) >= (64'd1 << PW_WIDTH)) begin : g_cfg_bad
      $error("uart_servo_cmd: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, GET_ANGLE, GET_CHK} state_t;

   state_t              state, state_n;
   logic [7:0]          shadow, shadow_n;
   logic [TW-1:0]       tcnt, tcnt_n;
   logic [7:0]          angle_n;
   logic [PW_WIDTH-1:0] pw_n, pw_calc;
   logic                upd_n, ferr_n, terr_n;

   assign pw_calc = PW_WIDTH'(MIN_CYCLES) + PW_WIDTH'(shadow) * PW_WIDTH'(STEP_CYCLES);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         shadow      <= '0;
         tcnt        <= '0;
         angle       <= 8'd90;
         pulse_width <= PW_RST;
         pw_update   <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         shadow      <= shadow_n;
         tcnt        <= tcnt_n;
         angle       <= angle_n;
         pulse_width <= pw_n;
         pw_update   <= upd_n;
         frame_err   <= ferr_n;
         timeout_err <= terr_n;
         busy        <= (state_n != IDLE);
      end
   end

   always_comb begin
      state_n  = state;
      shadow_n = shadow;
      tcnt_n   = tcnt;
      angle_n  = angle;
      pw_n     = pulse_width;
      upd_n    = 1'b0;
      ferr_n   = 1'b0;
      terr_n   = 1'b0;
      case (state)
         IDLE: begin
            tcnt_n = '0;
            if (rx_valid && rx_data == HEADER) state_n = GET_ANGLE;
         end
         GET_ANGLE, GET_CHK: begin
            // A byte on the timeout cycle takes priority over the timeout.
            if (rx_valid) begin
               tcnt_n = '0;
               if (state == GET_ANGLE) begin
                  shadow_n = rx_data;
                  state_n  = GET_CHK;
               end else begin
                  state_n = IDLE;
                  if (rx_data == ~shadow && shadow <= MAX_A8) begin
                     angle_n = shadow;
                     pw_n    = pw_calc;
                     upd_n   = 1'b1;
                  end else begin
                     ferr_n = 1'b1;
                  end
               end
            end else if (tcnt == TMO_LAST) begin
               state_n = IDLE;
               terr_n  = 1'b1;
               tcnt_n  = '0;
            end else begin
               tcnt_n = tcnt + TW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_servo_cmd.sv
// Directed bench for uart_servo_cmd: frame table plus hand-written timeout and
// reset sequences; timeout shortened so the run stays small.
module tb_uart_servo_cmd;
   localparam int TMO = 64;
   localparam int PW  = 20;

   logic          clk = 1'b0;
   logic          resetn;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic [PW-1:0] pulse_width;
   logic          pw_update;
   logic [7:0]    angle;
   logic          frame_err;
   logic          timeout_err;
   logic          busy;

   int errors = 0;
   int checks = 0;
   int excl_viol = 0;

   uart_servo_cmd #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
      .pulse_width(pulse_width), .pw_update(pw_update), .angle(angle),
      .frame_err(frame_err), .timeout_err(timeout_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (resetn && (int'(pw_update) + int'(frame_err) + int'(timeout_err)) > 1) excl_viol++;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic check_idle_quiet(input string name, input int pw_exp, input int ang_exp);
      check({name, " pw"}, int'(pulse_width), pw_exp);
      check({name, " angle"}, int'(angle), ang_exp);
      check({name, " strobes"}, {29'd0, pw_update, frame_err, timeout_err}, 0);
      check({name, " busy"}, int'(busy), 0);
   endtask

   typedef struct {
      logic [7:0] hdr, ang, chk;
      logic       upd, ferr;
      int         pw, angle;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{8'hAA, 8'h00, 8'hFF, 1'b1, 1'b0, 27000, 0};
      vecs[1] = '{8'hAA, 8'hB4, 8'h4B, 1'b1, 1'b0, 54000, 180};
      vecs[2] = '{8'hAA, 8'h5A, 8'h00, 1'b0, 1'b1, 54000, 180};
      vecs[3] = '{8'hAA, 8'hC8, 8'h37, 1'b0, 1'b1, 54000, 180};
      vecs[4] = '{8'hAA, 8'h5A, 8'hA5, 1'b1, 1'b0, 40500, 90};
      vecs[5] = '{8'hAA, 8'hB5, 8'h4A, 1'b0, 1'b1, 40500, 90};
      vecs[6] = '{8'hAA, 8'hAA, 8'h55, 1'b1, 1'b0, 52500, 170};
      vecs[7] = '{8'hAA, 8'h01, 8'hFE, 1'b1, 1'b0, 27150, 1};

      resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) tick();
      resetn = 1'b1;
      repeat (2) tick();
      check_idle_quiet("reset", 40500, 90);

      // Back-to-back frames from the table
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].hdr);
         check($sformatf("v%0d busy_hdr", i), int'(busy), 1);
         send(vecs[i].ang);
         send(vecs[i].chk);
         check($sformatf("v%0d upd", i), int'(pw_update), int'(vecs[i].upd));
         check($sformatf("v%0d ferr", i), int'(frame_err), int'(vecs[i].ferr));
         check($sformatf("v%0d terr", i), int'(timeout_err), 0);
         check($sformatf("v%0d pw", i), int'(pulse_width), vecs[i].pw);
         check($sformatf("v%0d angle", i), int'(angle), vecs[i].angle);
         check($sformatf("v%0d busy", i), int'(busy), 0);
         tick();
         check($sformatf("v%0d strobes_clr", i), {29'd0, pw_update, frame_err, timeout_err}, 0);
      end

      // Noise before a header is dropped silently
      send(8'h13);
      check_idle_quiet("noise13", 27150, 1);
      send(8'h55);
      check_idle_quiet("noise55", 27150, 1);
      send(8'hAA); send(8'h2D); send(8'hD2);
      check("noise_frame upd", int'(pw_update), 1);
      check("noise_frame pw", int'(pulse_width), 33750);
      check("noise_frame angle", int'(angle), 45);
      tick();

      // Inter-byte timeout: error lands TMO edges after the header edge
      send(8'hAA);
      begin
         int early = 0;
         for (int j = 1; j < TMO; j++) begin
            tick();
            if (timeout_err || !busy) early++;
         end
         check("tmo early", early, 0);
      end
      tick();
      check("tmo strobe", int'(timeout_err), 1);
      check("tmo busy", int'(busy), 0);
      tick();
      check("tmo strobe_clr", int'(timeout_err), 0);
      send(8'h2D); send(8'hD2);
      check_idle_quiet("tmo tail", 33750, 45);

      // Byte on the timeout-boundary cycle wins
      send(8'hAA);
      repeat (TMO - 1) tick();
      send(8'h1E);
      check("bnd terr", int'(timeout_err), 0);
      check("bnd busy", int'(busy), 1);
      send(8'hE1);
      check("bnd upd", int'(pw_update), 1);
      check("bnd pw", int'(pulse_width), 31500);
      check("bnd angle", int'(angle), 30);
      tick();

      // Reset mid-frame discards the partial frame
      send(8'hAA); send(8'h2D);
      #2 resetn = 1'b0;
      #1;
      check_idle_quiet("rst mid", 40500, 90);
      tick();
      resetn = 1'b1;
      tick();
      send(8'hD2);
      check_idle_quiet("rst tail", 40500, 90);
      tick();
      check("rst tail upd", int'(pw_update), 0);

      check("strobe exclusivity", excl_viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
